// File: rtl/multdiv_pkg.sv
// Shared types for the integer execute cluster: word widths, ALU function codes
// and the multiply/divide op encoding.
package multdiv_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [2*XLEN-1:0] dword_t;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_func_e;

  function automatic logic op_is_signed(input md_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/multdiv.sv
// Iterative 32-bit multiply/divide: one radix-2 step per cycle over 32 cycles,
// signed ops run on magnitudes and get their signs fixed on the last step.
module multdiv
  import multdiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  md_op_e     op_q, op_d;
  word_t      a_q, a_d, b_q, b_d;
  word_t      hi_q, hi_d, lo_q, lo_d;
  dword_t     acc_q, acc_d;

  md_op_e     in_op;
  logic       is_div, a_neg, b_neg;
  word_t      mag_a_in, mag_b;
  logic [32:0] add_sum, rem_sh, sub_diff;
  dword_t     acc_step, prod;
  word_t      quo, rem;

  assign in_op    = md_op_e'(op);
  assign in_ready = (state_q == S_IDLE);
  assign done     = (state_q == S_DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;

  // One shift-add or restoring shift-subtract step on the accumulator.
  always_comb begin
    is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    a_neg    = op_is_signed(op_q) && a_q[31];
    b_neg    = op_is_signed(op_q) && b_q[31];
    mag_b    = b_neg ? (~b_q + 32'd1) : b_q;
    mag_a_in = (op_is_signed(in_op) && a[31]) ? (~a + 32'd1) : a;
    add_sum  = {1'b0, acc_q[63:32]} + {1'b0, mag_b};
    rem_sh   = acc_q[63:31];
    sub_diff = rem_sh - {1'b0, mag_b};
    if (is_div)
      acc_step = sub_diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                              : {sub_diff[31:0], acc_q[30:0], 1'b1};
    else
      acc_step = acc_q[0] ? {add_sum, acc_q[31:1]}
                          : {1'b0, acc_q[63:32], acc_q[31:1]};
    prod = (a_neg ^ b_neg) ? (~acc_step + 64'd1) : acc_step;
    quo  = (a_neg ^ b_neg) ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
    rem  = a_neg ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          state_d = S_BUSY;
          cnt_d   = 5'd0;
          op_d    = in_op;
          a_d     = a;
          b_d     = b;
          acc_d   = {32'd0, mag_a_in};
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = 5'd0;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_DONE;
            if (!is_div) begin
              hi_d = prod[63:32];
              lo_d = prod[31:0];
            end else if (b_q == 32'd0) begin
              // Divide by zero: quotient all ones, remainder is the dividend.
              hi_d = a_q;
              lo_d = 32'hFFFF_FFFF;
            end else begin
              hi_d = rem;
              lo_d = quo;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Directed bench for multdiv: latency, signed/unsigned results, divide corner
// cases, flush in each state, async reset and back-to-back requests.
module tb_multdiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        done;
  logic [31:0] hi, lo;

  int nchk = 0;
  int nerr = 0;

  localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  multdiv dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .flush(flush), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and returns edges from accept to done (-1 on timeout).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int cyc);
    int w = 0;
    while (!in_ready && w < 50) begin step(); w++; end
    op = o; a = x; b = y; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; op = MULT; a = '0; b = '0;
    step(); step();
    reset = 1'b0;
    step();
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b exp=0", done); end
    nchk++; if (hi !== 32'd0) begin nerr++; $display("FAIL reset_hi got=%h exp=0", hi); end
    nchk++; if (lo !== 32'd0) begin nerr++; $display("FAIL reset_lo got=%h exp=0", lo); end
  endtask

  task automatic test_multu();
    int cyc;
    run_op(MULTU, 32'hFFFF_FFFF, 32'd2, cyc);
    nchk++; if (cyc !== 32) begin nerr++; $display("FAIL multu_latency got=%0d exp=32", cyc); end
    nchk++; if (hi !== 32'd1) begin nerr++; $display("FAIL multu_hi got=%h exp=1", hi); end
    nchk++; if (lo !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
    step();
    nchk++; if (done !== 1'b0 || in_ready !== 1'b1) begin nerr++; $display("FAIL done_pulse got done=%b rdy=%b exp 0/1", done, in_ready); end
    step(); step();
    nchk++; if (lo !== 32'hFFFF_FFFE || hi !== 32'd1) begin nerr++; $display("FAIL hold_idle got=%h_%h exp=00000001_fffffffe", hi, lo); end
  endtask

  task automatic test_mult();
    int cyc;
    run_op(MULT, 32'hFFFF_FFFD, 32'd7, cyc);
    nchk++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin nerr++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_ffffffeb", hi, lo); end
    run_op(MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, cyc);
    nchk++; if ({hi, lo} !== 64'h0000_0000_0000_001E) begin nerr++; $display("FAIL mult_negneg got=%h_%h exp=00000000_0000001e", hi, lo); end
    run_op(MULTU, 32'h8000_0000, 32'h8000_0000, cyc);
    nchk++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin nerr++; $display("FAIL multu_big got=%h_%h exp=40000000_00000000", hi, lo); end
  endtask

  task automatic test_div();
    int cyc;
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    nchk++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL div_neg got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
    run_op(DIV, 32'd7, 32'hFFFF_FFFE, cyc);
    nchk++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin nerr++; $display("FAIL div_negb got=%h_%h exp=00000001_fffffffd", hi, lo); end
    run_op(DIVU, 32'd7, 32'd0, cyc);
    nchk++; if (cyc !== 32) begin nerr++; $display("FAIL divz_latency got=%0d exp=32", cyc); end
    nchk++; if (hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL divu_zero got=%h_%h exp=00000007_ffffffff", hi, lo); end
    run_op(DIV, 32'hFFFF_FFF9, 32'd0, cyc);
    nchk++; if (hi !== 32'hFFFF_FFF9 || lo !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL div_zero got=%h_%h exp=fffffff9_ffffffff", hi, lo); end
    run_op(DIVU, 32'hFFFF_FFFF, 32'd16, cyc);
    nchk++; if (hi !== 32'd15 || lo !== 32'h0FFF_FFFF) begin nerr++; $display("FAIL divu_big got=%h_%h exp=0000000f_0fffffff", hi, lo); end
    run_op(DIVU, 32'd100, 32'd7, cyc);
    nchk++; if (hi !== 32'd2 || lo !== 32'd14) begin nerr++; $display("FAIL divu_small got=%h_%h exp=00000002_0000000e", hi, lo); end
  endtask

  task automatic test_overflow();
    int cyc;
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    nchk++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin nerr++; $display("FAIL div_ovf got=%h_%h exp=00000000_80000000", hi, lo); end
  endtask

  task automatic test_flush();
    int cyc, ndone;
    // Prior result: 100/7 -> hi=2, lo=14.
    run_op(DIVU, 32'd100, 32'd7, cyc);
    step();
    op = MULTU; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    nchk++; if (hi !== 32'd2 || lo !== 32'd14) begin nerr++; $display("FAIL flush_hold got=%h_%h exp=00000002_0000000e", hi, lo); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin step(); if (done) ndone++; end
    nchk++; if (ndone !== 0) begin nerr++; $display("FAIL flush_nodone got=%0d exp=0", ndone); end
    run_op(MULTU, 32'd3, 32'd5, cyc);
    nchk++; if (cyc !== 32 || lo !== 32'd15 || hi !== 32'd0) begin nerr++; $display("FAIL flush_next got cyc=%0d %h_%h exp 32 00000000_0000000f", cyc, hi, lo); end
    // Flush in IDLE blocks acceptance.
    step();
    op = MULTU; a = 32'd9; b = 32'd9; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL idle_flush_ready got=%b exp=1", in_ready); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin step(); if (done) ndone++; end
    nchk++; if (ndone !== 0 || lo !== 32'd15) begin nerr++; $display("FAIL idle_flush_block got done=%0d lo=%h exp 0 0000000f", ndone, lo); end
    // Flush in DONE does not disturb the committed result.
    op = MULTU; a = 32'd6; b = 32'd9; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (32) step();
    flush = 1'b1;
    nchk++; if (done !== 1'b1 || lo !== 32'd54) begin nerr++; $display("FAIL done_flush got done=%b lo=%h exp 1 00000036", done, lo); end
    step();
    flush = 1'b0;
    nchk++; if (in_ready !== 1'b1 || lo !== 32'd54) begin nerr++; $display("FAIL done_flush_after got rdy=%b lo=%h exp 1 00000036", in_ready, lo); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    op = MULTU; a = 32'd11; b = 32'd11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    nchk++; if (hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin nerr++; $display("FAIL async_reset got=%h_%h done=%b exp zeros", hi, lo, done); end
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL async_reset_ready got=%b exp=1", in_ready); end
    reset = 1'b0;
    step();
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_ready got=%b exp=1", in_ready); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin step(); if (done) ndone++; end
    nchk++; if (ndone !== 0 || lo !== 32'd0) begin nerr++; $display("FAIL post_reset_nodone got done=%0d lo=%h exp 0 0", ndone, lo); end
  endtask

  task automatic test_back_to_back();
    int ndone, first, second;
    ndone = 0; first = -1; second = -1;
    op = MULTU; a = 32'd6; b = 32'd7; in_valid = 1'b1;
    for (int i = 1; i <= 102; i++) begin
      step();
      if (done) begin
        ndone++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
    end
    in_valid = 1'b0;
    nchk++; if (ndone !== 3) begin nerr++; $display("FAIL b2b_count got=%0d exp=3", ndone); end
    nchk++; if (first !== 33 || second - first !== 34) begin nerr++; $display("FAIL b2b_spacing got first=%0d gap=%0d exp 33 34", first, second - first); end
    nchk++; if (lo !== 32'd42 || hi !== 32'd0) begin nerr++; $display("FAIL b2b_result got=%h_%h exp=00000000_0000002a", hi, lo); end
    repeat (40) step();
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/multdiv.md
MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_valid  in  1  request present.
REQ-004 SHALL have port: in_ready  out  1  block can accept a request this cycle.
REQ-005 SHALL have port: op  in  2  operation: MULT, MULTU, DIV, DIVU.
REQ-006 SHALL have port: a  in  32  operand A, or dividend for DIV/DIVU.
REQ-007 SHALL have port: b  in  32  operand B, or divisor for DIV/DIVU.
REQ-008 SHALL have port: flush  in  1  cancel the in-flight operation.
REQ-009 SHALL have port: done  out  1  one-cycle pulse; hi/lo hold a new result.
REQ-010 SHALL have port: hi  out  32  product[63:32], or remainder.
REQ-011 SHALL have port: lo  out  32  product[31:0], or quotient.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE.
REQ-014 SHALL accept a request at a rising edge where in_valid=1, in_ready=1 and flush=0; it latches op, a and b and moves to BUSY.
REQ-015 SHALL stay in BUSY for exactly 32 cycles, performing one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-016 SHALL move BUSY->DONE after the 32nd step and DONE->IDLE unconditionally one cycle later.
REQ-017 SHALL assert done only in DONE, giving fixed latency: accept edge, then 32 BUSY cycles, then done in the 33rd cycle after the accept edge.
REQ-018 SHALL update hi/lo only on entry to DONE and hold them otherwise, including across later idle periods.
REQ-019 SHALL handle signed ops (MULT/DIV) by operating on magnitudes; the 5-bit step counter counts 0..31.
REQ-020 SHALL negate the final 64-bit product when operand signs differ.
REQ-021 SHALL, for signed divide, give the quotient the sign of a XOR b and the remainder the sign of a.
REQ-022 SHALL return hi=a, lo=32'hFFFF_FFFF for a divide with b=0, after the normal latency.
REQ-023 SHALL return lo=32'h8000_0000, hi=0 for DIV with a=32'h8000_0000, b=32'hFFFF_FFFF; no trap is raised.
REQ-024 SHALL, on flush=1 in BUSY, return to IDLE at the next edge, suppress done and leave hi/lo unchanged.
REQ-025 SHALL let flush=1 in IDLE block acceptance that cycle; in_valid is ignored.
REQ-026 SHALL let flush=1 in DONE leave done and the hi/lo update intact; the result is already committed.
REQ-027 SHALL ignore in_valid while BUSY or DONE; the requester holds a, b and op until in_ready=1.

Reset
REQ-028 SHALL, on reset=1, immediately force state=IDLE, done=0, hi=0, lo=0 and clear the counter and datapath registers, regardless of clock.
REQ-029 SHALL discard a mid-operation reset silently; the first post-reset cycle has in_ready=1.

Structure
REQ-030 SHALL take the op encoding enum (MULT=0, MULTU=1, DIV=2, DIVU=3) and the 32/64-bit width types from the shared common package, alongside the ALU func encodings.
REQ-031 SHALL be one flat module with no sub-module; FSM, counter, 64-bit accumulator/remainder register and sign-fix logic all live in multdiv.

Verification
REQ-032 SHALL cover: MULTU a=32'hFFFF_FFFF, b=2 -> done at cycle 33; hi=1, lo=32'hFFFF_FFFE.
REQ-033 SHALL cover: MULT a=-3, b=7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
REQ-034 SHALL cover: DIV a=-7, b=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); DIVU a=7, b=0 -> hi=7, lo=32'hFFFF_FFFF.
REQ-035 SHALL cover: DIV a=32'h8000_0000, b=-1 -> lo=32'h8000_0000, hi=0.
REQ-036 SHALL cover: flush at BUSY cycle 10 -> no done; hi/lo keep the prior result; in_ready=1 the next cycle; a new request is accepted.
REQ-037 SHALL cover: async reset pulse mid-BUSY between clock edges -> outputs zero immediately; no done; back-to-back requests with in_valid held give one done per 34-cycle window.
